mealy_stream_arbiter: RTL and testbench
=======================================

# mealy_stream_arbiter

Round-robin scheduler sharing one serial Mealy transducer core among `N_REQ` requesters. Each accepted request carries a `WIDTH`-bit word. The block clears the core, shifts the word in LSB-first, and collects the core's same-cycle Mealy output into a result word. It then returns that word, the requester id and the core's final state. It sits between the requester-side valid/ready ports and the 3-bit-state transducer, and owns the core's `rst_n` and `in`.

## Interface
- `N_REQ`, default 4: number of requesters (≥2).
- `WIDTH`, default 8: bits per job (≥2).
- `IDW`, default $clog2(N_REQ): id width.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_valid`  in  N_REQ: per-requester job valid.
- `req_data`  in  N_REQ*WIDTH: job words; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready`  out  N_REQ: one-hot accept strobe.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: result consumed.
- `rsp_id`  out  IDW: requester that owns the result.
- `rsp_data`  out  WIDTH: collected core outputs; bit k = output for input bit k.
- `rsp_state`  out  3: core state after the last input bit.
- `core_rst_n`  out  1: drives the core's synchronous active-low reset.
- `core_in`  out  1: serial bit into the core.
- `core_out`  in  1: core Mealy output, combinational from `core_in` and the core state.
- `core_state`  in  3: core state register.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - **IDLE:** if any `req_valid`, grant one requester, assert its `req_ready`, latch its data and id, go to SHIFT. Otherwise stay in IDLE.
  - **SHIFT:** run for exactly `WIDTH` cycles, then go to CAPT.
  - **CAPT:** 1 cycle, then go to DONE.
  - **DONE:** hold until `rsp_ready`, then go to IDLE.
- Arbitration:
  - Round-robin pointer `last_grant` resets to N_REQ-1, so requester 0 wins first.
  - Search order is last_grant+1, +2, … modulo N_REQ; the first valid requester wins.
  - `last_grant` updates only on accept.
- `req_ready`:
  - Combinational, one-hot, asserted only in IDLE.
  - Forced to 0 while `rst_n`=0.
  - Acceptance = `req_valid[i] && req_ready[i]`.
- Core reset:
  - `core_rst_n` = `rst_n` && (state==SHIFT).
  - The core is held cleared in every other state, so it enters SHIFT in its reset state.
- SHIFT, cycle k (k=0..WIDTH-1):
  - `core_in` = latched bit k.
  - `core_out` is registered into the collect register, bit k, at the end of the cycle.
  - The bit counter is `$clog2(WIDTH)` wide and increments; leave SHIFT when the counter equals WIDTH-1.
- CAPT:
  - `core_in`=0; `core_rst_n`=0.
  - `core_state` is registered into `rsp_state` and the collect register into `rsp_data`.
  - `rsp_id` is loaded from the latched id.
- DONE:
  - `rsp_valid`=1.
  - `rsp_data`, `rsp_id` and `rsp_state` are stable until the handshake.
- Outside SHIFT, `core_in`=0.
- `rsp_*` registers hold their last values after the handshake.
- Requests whose `req_valid` drops before grant are not accepted. No buffering: one job in flight.

## Timing
- Accept at cycle t (IDLE). SHIFT covers t+1 … t+WIDTH. CAPT is t+WIDTH+1. `rsp_valid` rises at t+WIDTH+2.
- If `rsp_ready` is high at t+WIDTH+2, that cycle completes the handshake and the FSM is in IDLE at t+WIDTH+3. The earliest next accept is t+WIDTH+3, giving a job throughput of WIDTH+3 cycles.
- `rsp_ready` is ignored outside DONE.
- Backpressure: DONE holds indefinitely. During DONE, `core_rst_n`=0 and no `req_ready` is asserted.
- Simultaneous requests: exactly one grant per IDLE cycle, chosen by round-robin order.
- Reset values: state IDLE, `last_grant`=N_REQ-1, and all outputs 0 (`req_ready`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_state`, `core_rst_n`, `core_in`, `busy`).
- Reset mid-operation, in any state:
  - Next cycle is IDLE and the in-flight job is dropped; no response is produced.
  - The pointer is restored to its reset value.

## Structure
- Shared package `mealy_arb_pkg`:
  - FSM state enum: IDLE, SHIFT, CAPT, DONE.
  - Core state width constant = 3.
  - Default `WIDTH`/`N_REQ`.
- Sub-module `rr_arbiter`:
  - Combinational one-hot grant from request vector and `last_grant`.
  - Parameter `N_REQ`.
- The top holds the FSM, data/id latch, bit counter, collect register and response registers.

## Test plan
For all scenarios, the bench stub core sets `core_out`=`core_in`, and `core_state` counts 1-inputs modulo 8 (cleared by `core_rst_n`).
1. `req_valid`=4'b0001, data0=8'hA5, `rsp_ready`=1:
   - `req_ready`=4'b0001 at cycle 0.
   - `core_rst_n` high exactly cycles 1–8; `core_in` sequence 1,0,1,0,0,1,0,1.
   - `rsp_valid` at cycle 10 with id 0, data 8'hA5, state 4.
2. All four requesters valid and held, data i=8'h10+i:
   - Grants in order 0,1,2,3,0, spaced 11 cycles apart.
   - Responses carry the matching ids and data.
3. Fairness: after a grant to 2, assert `req_valid`=4'b1001 → requester 3 granted, then 0.
4. Backpressure: `rsp_ready`=0 for 6 cycles after `rsp_valid` →
   - `rsp_valid`, `rsp_data`, `rsp_id`, `rsp_state` stable.
   - No `req_ready` despite pending requests; `core_rst_n`=0.
   - Accept occurs the cycle after the handshake.
5. Reset mid-SHIFT (rst_n=0 for 1 cycle at SHIFT bit 3) →
   - All outputs 0 on the next cycle; no `rsp_valid` ever produced for that job.
   - With requesters 1 and 0 pending, requester 0 is granted first.
6. Data 8'hFF then 8'h00 back-to-back from requester 1 → states 0 (8 mod 8) and 0, data 8'hFF and 8'h00. This confirms the core is cleared between jobs.

Source files
------------

// File: rtl/mealy_arb_pkg.sv
// rtl/mealy_arb_pkg.sv - shared types and defaults for the Mealy stream arbiter
package mealy_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CAPT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam int CORE_SW   = 3;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_REQ = 4;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot grant
module rr_arbiter
  import mealy_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last_grant,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic             gnt_any
);

  logic found;
  int   idx;

  // Search starts just after the previous winner, so it has lowest priority.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
    gnt_any = found;
  end

endmodule

// File: rtl/mealy_stream_arbiter.sv
// rtl/mealy_stream_arbiter.sv - round-robin scheduler sharing one serial Mealy core
module mealy_stream_arbiter
  import mealy_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [CORE_SW-1:0]     rsp_state,
  output logic                   core_rst_n,
  output logic                   core_in,
  input  logic                   core_out,
  input  logic [CORE_SW-1:0]     core_state,
  output logic                   busy
);

  localparam int CW = $clog2(WIDTH);

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   coll_q, coll_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [CORE_SW-1:0] rsp_state_q, rsp_state_d;

  logic [N_REQ-1:0]   gnt;
  logic [IDW-1:0]     gnt_id;
  logic               gnt_any;
  logic               accept;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .gnt_any    (gnt_any)
  );

  assign req_ready  = (rst_n && state_q == ST_IDLE) ? gnt : '0;
  assign accept     = |(req_valid & req_ready);
  // The core only leaves reset while bits are streaming, so every job starts clean.
  assign core_rst_n = rst_n && (state_q == ST_SHIFT);
  assign core_in    = (state_q == ST_SHIFT) ? data_q[cnt_q] : 1'b0;
  assign rsp_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_state  = rsp_state_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    coll_d       = coll_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_state_d  = rsp_state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && gnt_any) begin
          state_d      = ST_SHIFT;
          last_grant_d = gnt_id;
          id_d         = gnt_id;
          data_d       = req_data[int'(gnt_id)*WIDTH +: WIDTH];
          cnt_d        = '0;
        end
      end
      ST_SHIFT: begin
        coll_d[cnt_q] = core_out;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_CAPT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CAPT: begin
        rsp_state_d = core_state;
        rsp_data_d  = coll_q;
        rsp_id_d    = id_q;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDW'(N_REQ - 1);
      id_q         <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      coll_q       <= '0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_state_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      coll_q       <= coll_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_state_q  <= rsp_state_d;
    end
  end

endmodule

// File: tb/tb_mealy_stream_arbiter.sv
// tb/tb_mealy_stream_arbiter.sv - directed self-checking bench for mealy_stream_arbiter
module tb_mealy_stream_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic [2:0]     rsp_state;
  logic           core_rst_n;
  logic           core_in;
  logic           core_out;
  logic [2:0]     core_state;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Stub core: echoes its input, state counts ones modulo 8.
  assign core_out = core_in;
  always @(posedge clk) begin
    if (!core_rst_n) core_state <= 3'd0;
    else             core_state <= core_state + {2'b00, core_in};
  end

  mealy_stream_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_state  (rsp_state),
    .core_rst_n (core_rst_n),
    .core_in    (core_in),
    .core_out   (core_out),
    .core_state (core_state),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    nxt();
    rst_n = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b0;
    nxt();
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_outs", {rsp_valid, rsp_id, rsp_data, rsp_state, core_rst_n, core_in, busy}, 0);
    req_valid = '0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic wait_grant(output int id, output int at);
    id = -1;
    at = 0;
    for (int n = 0; n < 40; n++) begin
      if (|req_ready) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) id = i;
        at = cyc_n;
        break;
      end
      nxt();
    end
    if (id < 0) check_eq("grant_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output int at);
    at = -1;
    for (int n = 0; n < 40; n++) begin
      nxt();
      if (rsp_valid) begin
        at = cyc_n;
        break;
      end
    end
    if (at < 0) check_eq("rsp_timeout", 0, 1);
  endtask

  int g, tg, tr, prev;
  logic [W-1:0] bits;
  int hi_cnt;
  logic [3:0] exp_st [5] = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd1};
  int exp_g [5] = '{0, 1, 2, 3, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // 1: single job, exact cycle timing
    do_reset();
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    check_eq("t1_ready_c0", req_ready, 4'b0001);
    check_eq("t1_core_rst_c0", core_rst_n, 0);
    hi_cnt = 0;
    for (int k = 0; k < W; k++) begin
      nxt();
      if (k == 0) req_valid = '0;
      bits[k] = core_in;
      hi_cnt += int'(core_rst_n);
    end
    check_eq("t1_core_in_seq", bits, 8'hA5);
    check_eq("t1_core_rst_hi", hi_cnt, 8);
    nxt();
    check_eq("t1_capt_core_rst", core_rst_n, 0);
    check_eq("t1_capt_no_valid", rsp_valid, 0);
    nxt();
    check_eq("t1_rsp_valid_c10", rsp_valid, 1);
    check_eq("t1_rsp_id", rsp_id, 0);
    check_eq("t1_rsp_data", rsp_data, 8'hA5);
    check_eq("t1_rsp_state", rsp_state, 4);
    nxt();
    check_eq("t1_idle_valid", rsp_valid, 0);
    check_eq("t1_idle_busy", busy, 0);
    check_eq("t1_hold_data", rsp_data, 8'hA5);

    // 2: all four requesters, round-robin order and 11-cycle spacing
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g, tg);
      check_eq("t2_grant", g, exp_g[i]);
      if (i > 0) check_eq("t2_spacing", tg - prev, 11);
      prev = tg;
      wait_rsp(tr);
      check_eq("t2_latency", tr - tg, 10);
      check_eq("t2_rsp_id", rsp_id, exp_g[i]);
      check_eq("t2_rsp_data", rsp_data, 8'h10 + exp_g[i]);
      check_eq("t2_rsp_state", rsp_state, exp_st[i]);
    end

    // 3: fairness after a grant to requester 2
    do_reset();
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    wait_grant(g, tg);
    check_eq("t3_first", g, 2);
    nxt();
    req_valid = 4'b1001;
    wait_rsp(tr);
    wait_grant(g, tg);
    check_eq("t3_second", g, 3);
    wait_rsp(tr);
    wait_grant(g, tg);
    check_eq("t3_third", g, 0);

    // 4: backpressure holds DONE
    do_reset();
    req_data[15:8] = 8'h3C;
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    wait_grant(g, tg);
    check_eq("t4_grant", g, 1);
    wait_rsp(tr);
    for (int i = 0; i < 6; i++) begin
      nxt();
      check_eq("t4_hold_valid", rsp_valid, 1);
      check_eq("t4_hold_rsp", {rsp_id, rsp_data, rsp_state}, {2'd1, 8'h3C, 3'd4});
      check_eq("t4_no_ready", req_ready, 0);
      check_eq("t4_core_rst", core_rst_n, 0);
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("t4_ready_in_done", req_ready, 0);
    nxt();
    check_eq("t4_accept_after_hs", req_ready, 4'b0010);

    // 5: reset during SHIFT drops the job and restores the pointer
    do_reset();
    req_data[7:0] = 8'hFF;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    wait_grant(g, tg);
    check_eq("t5_first", g, 0);
    nxt();
    req_valid = '0;
    nxt();
    nxt();
    nxt();
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    #1;
    check_eq("t5_outs_zero", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_state, core_rst_n, core_in, busy}, 0);
    req_valid = 4'b0011;
    #1;
    check_eq("t5_regrant", req_ready, 4'b0001);
    tg = cyc_n;
    nxt();
    req_valid = '0;
    wait_rsp(tr);
    check_eq("t5_rsp_latency", tr - tg, 10);
    check_eq("t5_rsp_id", rsp_id, 0);

    // 6: back-to-back jobs from requester 1 with the core cleared between them
    do_reset();
    req_data[15:8] = 8'hFF;
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    wait_grant(g, tg);
    check_eq("t6_grant_a", g, 1);
    nxt();
    req_data[15:8] = 8'h00;
    wait_rsp(tr);
    check_eq("t6_data_a", rsp_data, 8'hFF);
    check_eq("t6_state_a", rsp_state, 0);
    wait_grant(g, prev);
    check_eq("t6_grant_b", g, 1);
    check_eq("t6_spacing", prev - tg, 11);
    nxt();
    req_valid = '0;
    wait_rsp(tr);
    check_eq("t6_data_b", rsp_data, 8'h00);
    check_eq("t6_state_b", rsp_state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
